mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 27 ++
 rtl/mem_arbiter.sv | 54 +++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: instruction/data requester ports and the shared single-port memory bus.
interface mem_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_req;
  logic        d_rd_wr;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        mem_req;
  logic        mem_rd_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  modport master (
    input  i_req, i_addr, d_req, d_rd_wr, d_addr, d_wdata, mem_rdata, mem_ack,
    output i_rdata, i_ack, d_rdata, d_ack, mem_req, mem_rd_wr, mem_addr, mem_wdata
  );
  modport slave (
    output i_req, i_addr, d_req, d_rd_wr, d_addr, d_wdata, mem_rdata, mem_ack,
    input  i_rdata, i_ack, d_rdata, d_ack, mem_req, mem_rd_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and data access,
// data first, with instruction fetch forced through after STARVE_LIMIT data grants.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.master bus
);
  localparam int CW = $clog2(STARVE_LIMIT + 1) > 3 ? $clog2(STARVE_LIMIT + 1) : 3;
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] starve_cnt;
  logic grant_i, grant_d, done;
  always_comb begin
    grant_i   = state == IDLE && bus.i_req && (!bus.d_req || starve_cnt == CW'(STARVE_LIMIT));
    grant_d   = state == IDLE && bus.d_req && !grant_i;
    done      = state != IDLE && bus.mem_ack;
    state_nxt = grant_i ? BUSY_I : grant_d ? BUSY_D : done ? IDLE : state;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  assign bus.mem_req = state != IDLE;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      starve_cnt    <= '0;
      bus.i_ack     <= 1'b0;
      bus.d_ack     <= 1'b0;
      bus.i_rdata   <= '0;
      bus.d_rdata   <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.mem_rd_wr <= 1'b1;
    end else begin
      bus.i_ack <= done && state == BUSY_I;
      bus.d_ack <= done && state == BUSY_D;
      if (done && state == BUSY_I) bus.i_rdata <= bus.mem_rdata;
      if (done && state == BUSY_D && bus.mem_rd_wr) bus.d_rdata <= bus.mem_rdata;
      if (grant_i) begin
        bus.mem_addr  <= bus.i_addr;
        bus.mem_rd_wr <= 1'b1;
        bus.mem_wdata <= '0;
      end else if (grant_d) begin
        bus.mem_addr  <= bus.d_addr;
        bus.mem_rd_wr <= bus.d_rd_wr;
        bus.mem_wdata <= bus.d_wdata;
      end
      // counts data grants taken while a fetch is waiting; saturates at the limit
      if (state == IDLE)
        starve_cnt <= (!bus.i_req || grant_i) ? '0 :
                      (grant_d && starve_cnt != CW'(STARVE_LIMIT)) ? starve_cnt + CW'(1) : starve_cnt;
    end
endmodule
